// File: rtl/multi_tick_generator.sv
`default_nettype none
// ============================================================================
// Module  : multi_tick_generator
// Purpose : Runtime-programmable per-channel clock divider producing a
//           one-cycle tick and a 50% square wave; divisor swaps on wrap only.
// Rev     : 1.0
// ============================================================================
module multi_tick_generator #(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 27,
  parameter int DEFAULT_DIV = 100_000_000,
  parameter int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NUM_CH-1:0] en,
  input  logic              clear,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  output logic              cfg_err,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] sq
);

  localparam logic [CNT_W-1:0] c_default_div = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] c_one         = CNT_W'(1);
  localparam logic [CH_W:0]    c_num_ch      = (CH_W + 1)'(NUM_CH);

  logic cfg_ok;
  logic cfg_err_q, cfg_err_d;

  always_comb begin
    cfg_ok    = cfg_we && (cfg_div != '0) && ({1'b0, cfg_ch} < c_num_ch);
    cfg_err_d = cfg_we && !cfg_ok;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) cfg_err_q <= 1'b0;
    else        cfg_err_q <= cfg_err_d;
  end

  assign cfg_err = cfg_err_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] act_q, act_d;
    logic [CNT_W-1:0] shd_q, shd_d;
    logic             pend_q, pend_d;
    logic             tick_q, tick_d;
    logic             sq_q, sq_d;
    logic             wr;
    logic             wrap;
    logic [CNT_W-1:0] next_div;

    always_comb begin
      wr       = cfg_ok && (cfg_ch == CH_W'(i));
      wrap     = en[i] && (cnt_q == act_q - c_one);
      // Divisor for the next period: a same-cycle write beats the shadow.
      next_div = wr ? cfg_div : (pend_q ? shd_q : act_q);

      cnt_d  = cnt_q;
      act_d  = act_q;
      shd_d  = wr ? cfg_div : shd_q;
      pend_d = pend_q;
      tick_d = 1'b0;
      sq_d   = sq_q;

      if (clear) begin
        cnt_d  = '0;
        sq_d   = 1'b0;
        act_d  = next_div;
        pend_d = 1'b0;
      end else if (!en[i]) begin
        cnt_d  = '0;
        act_d  = next_div;
        pend_d = 1'b0;
      end else if (wrap) begin
        cnt_d  = '0;
        tick_d = 1'b1;
        sq_d   = ~sq_q;
        act_d  = next_div;
        pend_d = 1'b0;
      end else begin
        cnt_d = cnt_q + c_one;
        if (wr) pend_d = 1'b1;
      end
    end

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        cnt_q  <= '0;
        act_q  <= c_default_div;
        shd_q  <= c_default_div;
        pend_q <= 1'b0;
        tick_q <= 1'b0;
        sq_q   <= 1'b0;
      end else begin
        cnt_q  <= cnt_d;
        act_q  <= act_d;
        shd_q  <= shd_d;
        pend_q <= pend_d;
        tick_q <= tick_d;
        sq_q   <= sq_d;
      end
    end

    assign tick[i] = tick_q;
    assign sq[i]   = sq_q;
  end

endmodule
`default_nettype wire
